// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M-style multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between a requester (master) and the muldiv unit (slave).
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: one shift-add or restoring-subtract step per cycle on
// operand magnitudes, with the sign fixed up when the final step completes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t           r_state, w_state_nx;
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_b, r_acc, r_sh, r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;

  function automatic logic [XLEN-1:0] f_cneg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_cneg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  logic            w_accept, w_last, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_special_res;

  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (bus.op)
      OP_MULH, OP_DIV, OP_REM: begin
        w_a_sgn = 1'b1;
        w_b_sgn = 1'b1;
      end
      OP_MULHSU:                              w_a_sgn = 1'b1;
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU:     ;
      default:                                ;
    endcase
  end

  assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
  assign w_a_neg   = w_a_sgn && bus.a[XLEN-1];
  assign w_b_neg   = w_b_sgn && bus.b[XLEN-1];
  // A remainder follows the dividend's sign; products and quotients follow the XOR.
  assign w_neg     = (bus.op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div0    = bus.op[2] && (bus.b == '0);
  assign w_ovf     = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                     (bus.a == MIN_NEG) && (bus.b == '1);
  assign w_special = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (bus.op[1] ? bus.a : '1)
                                : (bus.op[1] ? '0 : bus.a);

  logic [XLEN-1:0] w_addend, w_mul_acc, w_mul_sh, w_div_acc, w_div_sh;
  logic [XLEN-1:0] w_acc_nx, w_sh_nx, w_mul_res, w_div_res, w_fin;
  logic [XLEN:0]   w_sum, w_trial;
  logic [2*XLEN-1:0] w_prod;
  logic            w_ge;

  assign w_addend  = r_sh[0] ? r_b : '0;
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_addend};
  assign w_mul_acc = w_sum[XLEN:1];
  assign w_mul_sh  = {w_sum[0], r_sh[XLEN-1:1]};

  assign w_trial   = {r_acc, r_sh[XLEN-1]} - {1'b0, r_b};
  assign w_ge      = ~w_trial[XLEN];
  assign w_div_acc = w_ge ? w_trial[XLEN-1:0] : {r_acc[XLEN-2:0], r_sh[XLEN-1]};
  assign w_div_sh  = {r_sh[XLEN-2:0], w_ge};

  assign w_acc_nx  = r_op[2] ? w_div_acc : w_mul_acc;
  assign w_sh_nx   = r_op[2] ? w_div_sh  : w_mul_sh;
  assign w_last    = (r_cnt == LAST_CNT);

  assign w_prod    = f_cneg2({w_acc_nx, w_sh_nx}, r_neg);
  assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_div_res = f_cneg(r_op[1] ? w_acc_nx : w_sh_nx, r_neg);
  assign w_fin     = r_op[2] ? w_div_res : w_mul_res;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nx = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (w_last) w_state_nx = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op  <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_sh  <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept) begin
        r_op  <= bus.op;
        r_b   <= f_cneg(bus.b, w_b_neg);
        r_sh  <= f_cneg(bus.a, w_a_neg);
        r_acc <= '0;
        r_cnt <= '0;
        r_neg <= w_neg;
        r_res <= w_special ? w_special_res : '0;
      end
    end else if (r_state == ST_CALC) begin
      r_acc <= w_acc_nx;
      r_sh  <= w_sh_nx;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_res <= w_fin;
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.result    = (r_state == ST_DONE) ? r_res : '0;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; legal values are even integers from 8 to 64.
REQ-002 Parameter: CNT_W, default $clog2(XLEN)+1, iteration counter width; derived from XLEN, never overridden.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operation request.
REQ-006 Port: in_ready  output  1  unit can accept a request.
REQ-007 Port: op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RV32M encoding).
REQ-008 Port: a  input  XLEN  rs1 operand.
REQ-009 Port: b  input  XLEN  rs2 operand.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer takes result.
REQ-012 Port: result  output  XLEN  operation result.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, CALC, DONE.
REQ-015 in_ready is 1 only in IDLE; a request is accepted on a rising edge with in_valid & in_ready, which registers op, a and b.
REQ-016 IDLE->CALC on accept; IDLE->DONE on accept of a special case (REQ-021, REQ-022).
REQ-017 CALC runs exactly XLEN iterations: one radix-2 shift-add step (multiply) or one restoring-subtract step (divide) per cycle; CALC->DONE after the last step.
REQ-018 Latency: out_valid rises XLEN+1 cycles after the accepting edge for normal ops, 1 cycle after for special cases.
REQ-019 DONE: out_valid=1 and result is stable until the edge where out_ready=1; then DONE->IDLE. A request cannot be accepted in that same cycle.
REQ-020 Multiply: operands are sign- or zero-extended per op to form a 2*XLEN product; MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
REQ-021 Divide by zero: DIV/DIVU result is all ones; REM/REMU result is a.
REQ-022 Signed overflow (a = most negative, b = -1): DIV result is a; REM result is 0.
REQ-023 Signed divide: magnitudes are divided unsigned; the quotient is negated when the operand signs differ; the remainder takes the sign of a (truncation toward zero).
REQ-024 in_valid, op, a and b changes during CALC/DONE do not affect the result in flight.
REQ-025 result equals 0 whenever out_valid=0.

Reset
REQ-026 reset=1 forces IDLE immediately, without waiting for a clock edge, even mid-CALC or in DONE; the in-flight operation is discarded.
REQ-027 Reset values: in_ready=1, out_valid=0, busy=0, result=0, counter=0, all datapath registers=0.
REQ-028 The first accept can occur on the first rising edge after reset deasserts.

Structure
REQ-029 A shared package muldiv_pkg holds the op encoding constants (OP_MUL..OP_REMU) and the state encoding (ST_IDLE, ST_CALC, ST_DONE).
REQ-030 The unit contains no sub-module; a single FSM drives one shared accumulator/shift register pair plus a counter.
REQ-031 The RTL contains no multiply or divide operators; target size is 150-300 lines.

Verification (XLEN=32)
REQ-032 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept.
REQ-033 MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-034 DIV a=0xFFFFFFF9, b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-035 DIVU a=0x1234, b=0 -> 0xFFFFFFFF; REMU a=0x1234, b=0 -> 0x1234; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; each with out_valid 1 cycle after accept.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> result and out_valid held, in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-037 Assert reset 10 cycles into CALC -> outputs at reset values immediately; a new MUL 3*4 accepted afterwards -> 0x0000000C.
